// File: rtl/n1_pbus_arb.sv
// N1 program-bus arbiter: shares one pipelined Wishbone target between
// master 0 (CPU side) and master 1 (debug/loader) with round-robin grant,
// cycle lock and outstanding-request bookkeeping.
module n1_pbus_arb #(
   parameter int unsigned ADR_WIDTH   = 14,
   parameter int unsigned DAT_WIDTH   = 16,
   parameter int unsigned OUTST_WIDTH = 2
) (
   input  logic                   clk_i,
   input  logic                   async_rst_i,
   // master 0
   input  logic                   m0_cyc_i,
   input  logic                   m0_stb_i,
   input  logic                   m0_we_i,
   input  logic [ADR_WIDTH-1:0]   m0_adr_i,
   input  logic [DAT_WIDTH-1:0]   m0_dat_i,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,
   output logic                   m0_stall_o,
   output logic [DAT_WIDTH-1:0]   m0_dat_o,
   // master 1
   input  logic                   m1_cyc_i,
   input  logic                   m1_stb_i,
   input  logic                   m1_we_i,
   input  logic [ADR_WIDTH-1:0]   m1_adr_i,
   input  logic [DAT_WIDTH-1:0]   m1_dat_i,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,
   output logic                   m1_stall_o,
   output logic [DAT_WIDTH-1:0]   m1_dat_o,
   // target
   output logic                   s_cyc_o,
   output logic                   s_stb_o,
   output logic                   s_we_o,
   output logic [ADR_WIDTH-1:0]   s_adr_o,
   output logic [DAT_WIDTH-1:0]   s_dat_o,
   input  logic                   s_ack_i,
   input  logic                   s_err_i,
   input  logic                   s_stall_i,
   input  logic [DAT_WIDTH-1:0]   s_dat_i,
   // probes
   output logic [1:0]             prb_arb_state_o,
   output logic [OUTST_WIDTH-1:0] prb_arb_outst_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_M0   = 2'd1,
      ST_M1   = 2'd2
   } arb_state_t;

   localparam logic [OUTST_WIDTH-1:0] OUTST_MAX = '1;
   localparam logic [OUTST_WIDTH-1:0] OUTST_ONE = OUTST_WIDTH'(1);

   arb_state_t             state;
   logic                   last;
   logic [OUTST_WIDTH-1:0] outst;

   logic own0_c;
   logic own1_c;
   logic sat_c;
   logic inc_c;
   logic dec_c;

   // Ownership, saturation and counter events derived from the registered grant
   assign own0_c = (state == ST_M0);
   assign own1_c = (state == ST_M1);
   assign sat_c  = (own0_c | own1_c) & (outst == OUTST_MAX);
   assign inc_c  = s_stb_o & ~s_stall_i;
   assign dec_c  = (s_ack_i | s_err_i) & (outst != '0);

   // Grant FSM with round-robin pick, cycle lock and outstanding counter
   always_ff @(posedge clk_i or negedge async_rst_i) begin
      if (!async_rst_i) begin
         state <= ST_IDLE;
         last  <= 1'b1;
         outst <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (m0_cyc_i && (!m1_cyc_i || last)) begin
                  state <= ST_M0;
               end else if (m1_cyc_i) begin
                  state <= ST_M1;
               end
            end
            ST_M0: begin
               if (!m0_cyc_i) begin
                  state <= m1_cyc_i ? ST_M1 : ST_IDLE;
                  last  <= 1'b0;
                  outst <= '0;
               end else if (inc_c != dec_c) begin
                  outst <= inc_c ? (outst + OUTST_ONE) : (outst - OUTST_ONE);
               end
            end
            ST_M1: begin
               if (!m1_cyc_i) begin
                  state <= m0_cyc_i ? ST_M0 : ST_IDLE;
                  last  <= 1'b1;
                  outst <= '0;
               end else if (inc_c != dec_c) begin
                  outst <= inc_c ? (outst + OUTST_ONE) : (outst - OUTST_ONE);
               end
            end
            default: begin
               state <= ST_IDLE;
               outst <= '0;
            end
         endcase
      end
   end

   // Owner's request is steered to the target; a saturated counter holds strobe off
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      if (own0_c) begin
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i & ~sat_c;
         s_we_o  = m0_we_i;
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
      end else if (own1_c) begin
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i & ~sat_c;
         s_we_o  = m1_we_i;
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
      end
   end

   // Responses reach the owner only; everyone else is held off with stall
   assign m0_ack_o   = own0_c & s_ack_i;
   assign m0_err_o   = own0_c & s_err_i;
   assign m0_stall_o = ~own0_c | s_stall_i | sat_c;
   assign m0_dat_o   = own0_c ? s_dat_i : '0;

   assign m1_ack_o   = own1_c & s_ack_i;
   assign m1_err_o   = own1_c & s_err_i;
   assign m1_stall_o = ~own1_c | s_stall_i | sat_c;
   assign m1_dat_o   = own1_c ? s_dat_i : '0;

   assign prb_arb_state_o = 2'(state);
   assign prb_arb_outst_o = outst;

endmodule

// File: doc/n1_pbus_arb.md
# N1_pbus_arb

Two-master arbiter for the N1 program bus (pipelined Wishbone). It shares one pbus target between master 0, the CPU side (flow-control fetch and memory I/O), and master 1, a debug/loader port. It owns bus-tenure sequencing:

- round-robin grant with cycle lock;
- request/acknowledge bookkeeping for pipelined transfers;
- routing of ack, err and read data back to the owning master.

## Interface
Parameters:
- ADR_WIDTH, 14, pbus word-address width
- DAT_WIDTH, 16, pbus data width
- OUTST_WIDTH, 2, outstanding-request counter width (max 2^OUTST_WIDTH-1 in flight)

Ports:
- clk_i  in  1  module clock
- async_rst_i  in  1  asynchronous reset, active-low
- mN_cyc_i  in  1  master N bus cycle indicator (N = 0, 1)
- mN_stb_i  in  1  master N access request
- mN_we_i  in  1  master N write enable
- mN_adr_i  in  ADR_WIDTH  master N address
- mN_dat_i  in  DAT_WIDTH  master N write data
- mN_ack_o  out  1  acknowledge to master N
- mN_err_o  out  1  error to master N
- mN_stall_o  out  1  stall to master N
- mN_dat_o  out  DAT_WIDTH  read data to master N
- s_cyc_o / s_stb_o / s_we_o  out  1  target cycle / request / write enable
- s_adr_o  out  ADR_WIDTH  target address
- s_dat_o  out  DAT_WIDTH  target write data
- s_ack_i / s_err_i / s_stall_i  in  1  target acknowledge / error / stall
- s_dat_i  in  DAT_WIDTH  target read data
- prb_arb_state_o  out  2  state: 0 IDLE, 1 M0, 2 M1
- prb_arb_outst_o  out  OUTST_WIDTH  outstanding-request count

## Operation
- State machine: IDLE, M0, M1.
- Registered state:
  - state;
  - last-served flag `last`, reset value 1, so master 0 wins the first contention;
  - outstanding counter `outst`.
- IDLE:
  - only m0_cyc_i -> M0;
  - only m1_cyc_i -> M1;
  - both -> the master not equal to `last`.
- Mx (owner x):
  - owner's cyc/stb/we/adr/dat are driven to s_*; s_cyc_o = mx_cyc_i;
  - s_ack_i, s_err_i, s_dat_i are routed to the owner only;
  - the non-owner sees ack=0, err=0, dat_o=0 and stall=1;
  - grant is locked while mx_cyc_i=1, i.e. no preemption.
- Release, when the owner drops cyc in Mx:
  - if the other master's cyc=1 -> go directly to that master's state;
  - otherwise -> IDLE;
  - `last` <= x; `outst` <= 0, because dropping cyc aborts in-flight transfers per Wishbone.
- Outstanding counter:
  - +1 when s_stb_o & !s_stall_i;
  - -1 when s_ack_i | s_err_i;
  - both in the same cycle -> unchanged;
  - never underflows: ack/err arriving at 0 is forwarded to the owner but does not decrement.
- Saturation: when `outst` = 2^OUTST_WIDTH-1, the owner's stall is forced to 1 and s_stb_o to 0 until a decrement.
- Owner stall: mx_stall_o = s_stall_i | saturated.
- Outputs in IDLE:
  - all s_* outputs 0;
  - mN_stall_o = 1, mN_ack_o = 0, mN_err_o = 0.

## Timing
- Reset (async_rst_i=0):
  - state IDLE, `last` = 1, `outst` = 0;
  - all s_* outputs 0;
  - mN_ack_o = mN_err_o = 0, mN_stall_o = 1, mN_dat_o = 0;
  - asserting reset mid-transfer aborts immediately, with no drain.
- Grant latency: master's cyc rises in cycle t -> s_cyc_o in cycle t+1. The master sees stall=1 in cycle t.
- The data path is combinational through the registered grant: address/data to s_*, and ack/err/dat back to the master, all in 0 cycles.
- Handover: owner cyc low in cycle t -> other master's s_cyc_o in cycle t+1. s_cyc_o is low for at least cycle t.
- Back-to-back pipelined requests: one accepted per cycle while s_stall_i=0 and the counter is not saturated.

## Test plan
- Single master 0 burst:
  - stimulus: reset released, m0 cyc/stb with 3 reads, adr 0x0010..0x0012, target ack 1 cycle after each accept, s_dat_i 0xA5A0+i;
  - required: s_cyc_o rises 1 cycle after m0_cyc_i; m0 receives 3 acks with 0xA5A0..0xA5A2; `outst` peaks at 1; m1 signals stay idle.
- Contention:
  - stimulus: m0 and m1 raise cyc in the same cycle after reset;
  - required: grant M0; m1_stall_o=1 throughout.
  - stimulus: m0 drops cyc;
  - required: M1 next cycle with no IDLE.
  - stimulus: both request again;
  - required: M0 granted (round-robin).
- Saturation:
  - stimulus: OUTST_WIDTH=2, target never acks, m0 issues 4 strobes;
  - required: 3 accepted; then m0_stall_o=1 and s_stb_o=0.
  - stimulus: one ack;
  - required: 4th request accepted next cycle.
- Error routing:
  - stimulus: M1 owner, s_err_i on its 2nd request;
  - required: m1_err_o=1 for one cycle, m0_err_o=0, `outst` decrements.
- Abort and reset:
  - stimulus: m1 drops cyc with `outst`=2;
  - required: `outst`=0, state IDLE.
  - stimulus: async_rst_i pulsed low during an M0 burst;
  - required: all outputs at reset values within the same cycle, prb_arb_state_o=0.
